// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite response codes and state types for the register bank slave.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axilite_regfile.sv
// NUM_REGS x 32-bit storage: one byte-strobed write port, one combinational read port,
// flat export of every register, synchronous active-low clear.
module axilite_regfile #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         widx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic [IDX_W-1:0]         ridx,
    output logic [31:0]              rdata,
    output logic [NUM_REGS*32-1:0]   regs_flat
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read sees the stored value before any write landing on the same edge.
    assign rdata = mem[ridx];

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[32*i +: 32] = mem[i];
    end

endmodule

// File: rtl/axilite_s_regbank.sv
// AXI4-Lite slave terminating all five channels in front of a byte-strobed register bank.
// Independent write (AW/W capture -> B) and read (AR -> R) state machines.
module axilite_s_regbank
    import axilite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_W-1:0]       s_axi_awaddr,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_W-1:0]       s_axi_araddr,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic [NUM_REGS*32-1:0]  regs_flat
);

    localparam int                IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * NUM_REGS);

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic [ADDR_W-1:0] wr_off, rd_off;
    logic              wr_hit, rd_hit, commit, aw_hs, w_hs, ar_hs;
    logic [31:0]       rf_rdata;

    // Offsets wrap modulo 2^ADDR_W, so addresses below the base land out of range.
    assign wr_off = aw_addr_q - BASE_ADDR;
    assign rd_off = s_axi_araddr - BASE_ADDR;
    assign wr_hit = wr_off < SPAN;
    assign rd_hit = rd_off < SPAN;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = (wr_state == WR_IDLE) && aw_held && w_held;

    axilite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .we        (commit && wr_hit),
        .widx      (wr_off[IDX_W+1:2]),
        .wdata     (w_data_q),
        .wstrb     (w_strb_q),
        .ridx      (rd_off[IDX_W+1:2]),
        .rdata     (rf_rdata),
        .regs_flat (regs_flat)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_state      <= WR_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= s_axi_wdata;
                        w_strb_q <= s_axi_wstrb;
                    end
                    s_axi_awready <= !(aw_held || aw_hs);
                    s_axi_wready  <= !(w_held || w_hs);
                    if (commit) begin
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                        wr_state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state      <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        s_axi_rdata   <= rd_hit ? rf_rdata : 32'h0;
                        s_axi_rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rd_state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= RD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_s_regbank.sv
// Directed and randomized bench for axilite_s_regbank against an array-based register model.
module tb_axilite_s_regbank;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] regs_flat;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [16];

    always #5 clk = ~clk;

    axilite_s_regbank #(
        .ADDR_W    (32),
        .NUM_REGS  (16),
        .BASE_ADDR (32'h0)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .regs_flat     (regs_flat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Register-bank model: 16 words at byte addresses 0x00..0x3F, everything else errors.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        if (addr >= 32'd64) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, regs_flat[32*i +: 32], model[i]);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int hold, input string tag);
        logic [1:0] exp_resp;
        logic aw_sent, w_sent, aw_fire, w_fire;
        int cnt, lat;
        exp_resp = model_write(addr, data, strb);
        aw_sent = 1'b0;
        w_sent  = 1'b0;
        cnt     = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        bready  = (hold == 0);
        while (!(aw_sent && w_sent) && cnt < 50) begin
            if (cnt >= w_lead && !aw_sent) awvalid = 1'b1;
            if (w_sent && !aw_sent) check({tag, "_wready_wait"}, 32'(wready), 32'd0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cnt++;
            if (aw_fire) begin aw_sent = 1'b1; awvalid = 1'b0; end
            if (w_fire)  begin w_sent  = 1'b1; wvalid  = 1'b0; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, "_accepted"}, 32'({aw_sent, w_sent}), 32'd3);
        lat = 0;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        check({tag, "_b_latency"}, lat, 32'd1);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick();
            check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
            check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
            check({tag, "_awready_resp"}, 32'(awready), 32'd0);
            check({tag, "_wready_resp"}, 32'(wready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_bvalid_done"}, 32'(bvalid), 32'd0);
        check({tag, "_awready_done"}, 32'(awready), 32'd1);
        check({tag, "_wready_done"}, 32'(wready), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, input string tag);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int cnt;
        exp_data = (addr < 32'd64) ? model[addr[5:2]] : 32'h0;
        exp_resp = (addr < 32'd64) ? 2'b00 : 2'b10;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        cnt = 0;
        while (!arready && cnt < 20) begin tick(); cnt++; end
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick();
            check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            check({tag, "_rdata"}, rdata, exp_data);
            check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
            check({tag, "_arready_data"}, 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
        check({tag, "_arready_done"}, 32'(arready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] addr;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        repeat (3) tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);

        aresetn = 1'b1;
        tick();
        check("release_awready_first_edge", 32'(awready), 32'd1);
        repeat (2) tick();
        check("idle_awready", 32'(awready), 32'd1);
        check("idle_wready", 32'(wready), 32'd1);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_bvalid", 32'(bvalid), 32'd0);
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check_all_regs("idle_regs");

        axi_write(32'h04, 32'hDEADBEEF, 4'b1111, 0, 0, "wr_deadbeef");
        check("reg1_deadbeef", regs_flat[63:32], 32'hDEADBEEF);
        axi_read(32'h04, 0, "rd_deadbeef");

        axi_write(32'h08, 32'hFFFFFFFF, 4'b1111, 0, 0, "wr_reg2_ones");
        axi_write(32'h08, 32'h11223344, 4'b0101, 2, 0, "wr_w_first");
        check("reg2_strobed", regs_flat[95:64], 32'hFF22FF44);

        axi_write(32'h40, 32'h0BADF00D, 4'b1111, 0, 0, "wr_oor");
        check_all_regs("oor_regs_unchanged");
        axi_read(32'h40, 0, "rd_oor");

        axi_write(32'h10, 32'hCAFEF00D, 4'b1111, 0, 5, "wr_bp");
        axi_read(32'h10, 5, "rd_bp");
        axi_write(32'h14, 32'h12345678, 4'b0000, 0, 0, "wr_nostrb");
        check("reg5_nostrb", regs_flat[191:160], 32'h0);

        axi_write(32'h0C, 32'hA5A5A5A5, 4'b1111, 0, 0, "wr_reg3_old");
        awaddr = 32'h0C; wdata = 32'h5A5A5A5A; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("same_edge_bvalid", 32'(bvalid), 32'd1);
        check("same_edge_rvalid", 32'(rvalid), 32'd1);
        check("same_edge_rdata_old", rdata, 32'hA5A5A5A5);
        void'(model_write(32'h0C, 32'h5A5A5A5A, 4'b1111));
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("same_edge_reg3_new", regs_flat[127:96], 32'h5A5A5A5A);
        check("same_edge_bvalid_done", 32'(bvalid), 32'd0);
        check("same_edge_rvalid_done", 32'(rvalid), 32'd0);

        awaddr = 32'h0C; wdata = 32'h13572468; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("pre_reset_bvalid", 32'(bvalid), 32'd1);
        aresetn = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        check("reset_resp_bvalid", 32'(bvalid), 32'd0);
        check("reset_resp_reg3", regs_flat[127:96], 32'h0);
        check("reset_resp_awready", 32'(awready), 32'd0);
        aresetn = 1'b1;
        tick();
        check("rerelease_awready", 32'(awready), 32'd1);
        check_all_regs("rerelease_regs");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd_wr");
            else
                axi_read(addr, int'($urandom_range(0, 2)), "rnd_rd");
        end
        check_all_regs("final_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
